// File: rtl/mem_if.sv
// Memory interface stage ahead of the MDR: MAR register plus a single-word
// req/ack read/write sequencer toward word-addressed RAM, with ack timeout.
module mem_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              mar_in,
    input  logic [DATA_W-1:0] mdr_q,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] mdata_in,
    output logic              mem_done,
    output logic              busy,
    output logic              mem_err,
    output logic [ADDR_W-1:0] mar_q,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                r_tmo;
    logic                w_tmo_nxt;
    logic [ADDR_W-1:0]   w_mar_nxt;
    logic [DATA_W-1:0]   w_mdata_nxt;
    logic                w_done_nxt;
    logic                w_busy_nxt;
    logic                w_err_nxt;
    logic                w_req_nxt;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_unused_bus;

    // Only the low ADDR_W bus bits address RAM.
    assign w_unused_bus = ^BusMuxOut[DATA_W-1:ADDR_W];

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if ((read ^ write) == 1'b1) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for every registered output; the transaction address and
    // data are latched at issue so later MAR loads cannot disturb them.
    always_comb begin
        w_mar_nxt   = mar_in ? BusMuxOut[ADDR_W-1:0] : mar_q;
        w_mdata_nxt = mdata_in;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = busy;
        w_req_nxt   = mem_req;
        w_we_nxt    = mem_we;
        w_addr_nxt  = mem_addr;
        w_wdata_nxt = mem_wdata;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            ST_IDLE: begin
                if (read && write) begin
                    w_err_nxt = 1'b1;
                end else if (read || write) begin
                    w_addr_nxt = mar_q;
                    w_we_nxt   = write;
                    w_req_nxt  = 1'b1;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = 8'd0;
                    w_tmo_nxt  = 1'b0;
                    if (write) begin
                        w_wdata_nxt = mdr_q;
                    end else begin
                        w_wdata_nxt = mem_wdata;
                    end
                end else begin
                    w_req_nxt = 1'b0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (!mem_we) begin
                        w_mdata_nxt = mem_rdata;
                    end else begin
                        w_mdata_nxt = mdata_in;
                    end
                    w_req_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_req_nxt = 1'b0;
                    w_we_nxt  = 1'b0;
                    w_tmo_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                // Timeout error is reported together with completion.
                w_done_nxt = 1'b1;
                w_err_nxt  = r_tmo;
                w_busy_nxt = 1'b0;
                w_tmo_nxt  = 1'b0;
            end
            default: begin
                w_req_nxt  = 1'b0;
                w_we_nxt   = 1'b0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mar_q     <= {ADDR_W{1'b0}};
            mdata_in  <= {DATA_W{1'b0}};
            mem_done  <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            r_cnt     <= 8'd0;
            r_tmo     <= 1'b0;
        end else begin
            mar_q     <= w_mar_nxt;
            mdata_in  <= w_mdata_nxt;
            mem_done  <= w_done_nxt;
            mem_err   <= w_err_nxt;
            busy      <= w_busy_nxt;
            mem_req   <= w_req_nxt;
            mem_we    <= w_we_nxt;
            mem_addr  <= w_addr_nxt;
            mem_wdata <= w_wdata_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

endmodule

// File: tb/tb_mem_if.sv
// Directed self-checking bench for mem_if: read, write, timeout, conflicts,
// mid-transaction reset and same-cycle MAR load.
module tb_mem_if;

    logic        clock;
    logic        reset;
    logic [31:0] BusMuxOut;
    logic        mar_in;
    logic [31:0] mdr_q;
    logic        read;
    logic        write;
    logic [31:0] mdata_in;
    logic        mem_done;
    logic        busy;
    logic        mem_err;
    logic [8:0]  mar_q;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_total = 0;
    int n_bad   = 0;
    int n_req;

    mem_if #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .BusMuxOut(BusMuxOut), .mar_in(mar_in),
        .mdr_q(mdr_q), .read(read), .write(write), .mdata_in(mdata_in),
        .mem_done(mem_done), .busy(busy), .mem_err(mem_err), .mar_q(mar_q),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; BusMuxOut = 32'h0; mar_in = 1'b0; mdr_q = 32'h0;
        read = 1'b0; write = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_mar",   mar_q,    64'h0);
        chk("rst_req",   mem_req,  64'h0);
        chk("rst_busy",  busy,     64'h0);
        chk("rst_mdata", mdata_in, 64'h0);
        chk("rst_done",  {mem_done, mem_err, mem_we}, 64'h0);
        reset = 1'b1;
        tick();

        // Read with ack in the third REQ cycle
        BusMuxOut = 32'h0000_0042; mar_in = 1'b1;
        tick();
        mar_in = 1'b0;
        chk("rd_mar", mar_q, 64'h042);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("rd_req1", mem_req, 64'h1);
        chk("rd_addr", mem_addr, 64'h042);
        chk("rd_we", mem_we, 64'h0);
        chk("rd_busy", busy, 64'h1);
        tick();
        chk("rd_req2", mem_req, 64'h1);
        tick();
        chk("rd_req3", mem_req, 64'h1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("rd_req_off", mem_req, 64'h0);
        chk("rd_done_early", mem_done, 64'h0);
        chk("rd_mdata", mdata_in, 64'hDEAD_BEEF);
        tick();
        chk("rd_done", mem_done, 64'h1);
        chk("rd_busy_off", busy, 64'h0);
        tick();
        chk("rd_done_once", mem_done, 64'h0);

        // Write, ack already present on first REQ cycle
        BusMuxOut = 32'h0000_01FF; mar_in = 1'b1;
        tick();
        mar_in = 1'b0;
        mdr_q = 32'h1234_5678; write = 1'b1; mem_ack = 1'b1;
        tick();
        write = 1'b0; mdr_q = 32'h0;
        chk("wr_req", mem_req, 64'h1);
        chk("wr_we", mem_we, 64'h1);
        chk("wr_wdata", mem_wdata, 64'h1234_5678);
        chk("wr_addr", mem_addr, 64'h1FF);
        tick();
        mem_ack = 1'b0;
        chk("wr_req_off", {mem_req, mem_we, mem_done}, 64'h0);
        tick();
        chk("wr_done", mem_done, 64'h1);
        chk("wr_mdata", mdata_in, 64'hDEAD_BEEF);
        tick();

        // Timeout: no ack at all
        read = 1'b1;
        tick();
        read = 1'b0;
        n_req = 0;
        while (mem_req && n_req < 40) begin
            n_req++;
            tick();
        end
        chk("to_req_cycles", n_req, 64'd15);
        chk("to_pre", {mem_done, mem_err}, 64'h0);
        tick();
        chk("to_done_err", {mem_done, mem_err}, 64'h3);
        chk("to_mdata", mdata_in, 64'hDEAD_BEEF);
        tick();
        chk("to_clear", {mem_done, mem_err, busy}, 64'h0);

        // read and write together in IDLE
        read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        chk("cf_err", mem_err, 64'h1);
        chk("cf_noreq", {mem_req, busy}, 64'h0);
        tick();
        chk("cf_err_pulse", {mem_err, mem_req}, 64'h0);

        // read and mar_in during REQ, read during DONE
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("bz_addr0", mem_addr, 64'h1FF);
        read = 1'b1; mar_in = 1'b1; BusMuxOut = 32'h0000_00AB;
        tick();
        read = 1'b0; mar_in = 1'b0;
        chk("bz_mar", mar_q, 64'h0AB);
        chk("bz_addr", mem_addr, 64'h1FF);
        chk("bz_err", mem_err, 64'h0);
        mem_ack = 1'b1; mem_rdata = 32'h55AA_33CC;
        tick();
        mem_ack = 1'b0;
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("bz_done", {mem_done, mem_req, mem_err}, 64'h4);
        tick();
        chk("bz_single", {mem_done, mem_req, busy}, 64'h0);
        chk("bz_mdata", mdata_in, 64'h55AA_33CC);

        // Reset during REQ, then a late ack
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("rs_req", mem_req, 64'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rs_ctrl", {mem_req, mem_we, busy, mem_done, mem_err}, 64'h0);
        chk("rs_data", {mar_q, mem_addr}, 64'h0);
        chk("rs_mdata", mdata_in, 64'h0);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        chk("rs_late_ack", {mem_req, busy, mem_done}, 64'h0);
        chk("rs_late_mdata", mdata_in, 64'h0);
        tick();
        chk("rs_no_done", {mem_done, mem_err}, 64'h0);

        // Same-cycle mar_in and read use the old MAR
        BusMuxOut = 32'h0000_0010; mar_in = 1'b1;
        tick();
        BusMuxOut = 32'h0000_0020; read = 1'b1;
        tick();
        mar_in = 1'b0; read = 1'b0;
        chk("sc_addr", mem_addr, 64'h010);
        chk("sc_mar", mar_q, 64'h020);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("sc_done", mem_done, 64'h1);
        chk("sc_mdata", mdata_in, 64'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
